// File: rtl/std_fifo_ctrl.sv
// FIFO pointer/occupancy controller for an external dual-port RAM.
// Generates RAM enables and addresses, occupancy flags and read-data-valid.
module std_fifo_ctrl #(
    parameter int WORD_SIZE         = 8,
    parameter int ADDRESS_WIDTH     = (WORD_SIZE >= 2) ? $clog2(WORD_SIZE) : 1,
    parameter int COUNT_WIDTH       = $clog2(WORD_SIZE + 1),
    parameter int ALMOST_FULL_LEVEL = WORD_SIZE - 1,
    parameter int BUFFER_OUT        = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_almost_full,
    output logic [COUNT_WIDTH-1:0]   o_count,
    output logic                     o_ram_we,
    output logic [ADDRESS_WIDTH-1:0] o_ram_waddr,
    output logic                     o_ram_re,
    output logic [ADDRESS_WIDTH-1:0] o_ram_raddr,
    output logic                     o_rdata_valid
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR  = ADDRESS_WIDTH'(WORD_SIZE - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE   = ADDRESS_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0]   FULL_COUNT = COUNT_WIDTH'(WORD_SIZE);
    localparam logic [COUNT_WIDTH-1:0]   AF_COUNT   = COUNT_WIDTH'(ALMOST_FULL_LEVEL);
    localparam logic [COUNT_WIDTH-1:0]   COUNT_ONE  = COUNT_WIDTH'(1);

    logic [ADDRESS_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDRESS_WIDTH-1:0] rptr_q, rptr_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic                     push_ok;
    logic                     pop_ok;

    // Flags come from the registered count only, so full/empty never see
    // this cycle's request and push/pop acceptance has no combinational loop.
    assign o_count       = count_q;
    assign o_empty       = (count_q == '0);
    assign o_full        = (count_q == FULL_COUNT);
    assign o_almost_full = (count_q >= AF_COUNT);

    assign push_ok = i_push && !o_full  && !i_clr;
    assign pop_ok  = i_pop  && !o_empty && !i_clr;

    assign o_ram_we    = push_ok;
    assign o_ram_waddr = wptr_q;
    assign o_ram_re    = pop_ok;
    assign o_ram_raddr = rptr_q;

    // NOTE: every next-state signal gets its default first, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (i_clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) wptr_d = (wptr_q == LAST_ADDR) ? '0 : wptr_q + ADDR_ONE;
            if (pop_ok)  rptr_d = (rptr_q == LAST_ADDR) ? '0 : rptr_q + ADDR_ONE;
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + COUNT_ONE;
                2'b01:   count_d = count_q - COUNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values. Only pointers and count are reset; the RAM
    // itself lives outside this block and keeps its contents.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    generate
        if (BUFFER_OUT != 0) begin : g_registered_read
            logic rvalid_q;
            // pop_ok is already forced low by i_clr, so clear needs no extra term.
            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) rvalid_q <= 1'b0;
                else        rvalid_q <= pop_ok;
            end
            assign o_rdata_valid = rvalid_q;
        end else begin : g_comb_read
            assign o_rdata_valid = pop_ok;
        end
    endgenerate

endmodule

// File: tb/tb_std_fifo_ctrl.sv
// Self-checking bench for std_fifo_ctrl: an 8-deep registered-read instance and a
// 5-deep combinational-read instance share stimulus and are checked against a queue-level model.
`timescale 1ns/1ps
module tb_std_fifo_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_clr = 1'b0;
    logic i_push = 1'b0;
    logic i_pop = 1'b0;

    logic       a_full, a_empty, a_af, a_we, a_re, a_rvalid;
    logic [3:0] a_count;
    logic [2:0] a_waddr, a_raddr;
    logic       b_full, b_empty, b_af, b_we, b_re, b_rvalid;
    logic [2:0] b_count;
    logic [2:0] b_waddr, b_raddr;

    int checks = 0;
    int failures = 0;

    // Model: occupancy and pointers as plain integers with modulo wrap.
    localparam int DEPTH[2]  = '{8, 5};
    localparam int AFLVL[2]  = '{7, 4};
    localparam int BUFOUT[2] = '{1, 0};
    int m_cnt[2];
    int m_wp[2];
    int m_rp[2];
    int m_rv[2];

    always #10 clk = ~clk;

    std_fifo_ctrl #(.WORD_SIZE(8), .BUFFER_OUT(1)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_clr(i_clr), .i_push(i_push), .i_pop(i_pop),
        .o_full(a_full), .o_empty(a_empty), .o_almost_full(a_af), .o_count(a_count),
        .o_ram_we(a_we), .o_ram_waddr(a_waddr), .o_ram_re(a_re), .o_ram_raddr(a_raddr),
        .o_rdata_valid(a_rvalid)
    );

    std_fifo_ctrl #(.WORD_SIZE(5), .BUFFER_OUT(0)) dut5 (
        .i_clk(clk), .i_rst(rst), .i_clr(i_clr), .i_push(i_push), .i_pop(i_pop),
        .o_full(b_full), .o_empty(b_empty), .o_almost_full(b_af), .o_count(b_count),
        .o_ram_we(b_we), .o_ram_waddr(b_waddr), .o_ram_re(b_re), .o_ram_raddr(b_raddr),
        .o_rdata_valid(b_rvalid)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare one instance against the model for the current cycle, then advance the model
    // to the state it must hold after the coming rising edge.
    task automatic model_cycle(input int k, input int cnt_o, input int full_o, input int empty_o,
                               input int af_o, input int we_o, input int waddr_o, input int re_o,
                               input int raddr_o, input int rv_o);
        int push_ok, pop_ok, exp_rv;
        string p;
        p = (k == 0) ? "d8" : "d5";
        push_ok = (i_push && !i_clr && m_cnt[k] < DEPTH[k]) ? 1 : 0;
        pop_ok  = (i_pop  && !i_clr && m_cnt[k] > 0) ? 1 : 0;
        exp_rv  = (BUFOUT[k] != 0) ? m_rv[k] : pop_ok;
        check({p, "_count"}, cnt_o, m_cnt[k]);
        check({p, "_full"},  full_o, (m_cnt[k] == DEPTH[k]) ? 1 : 0);
        check({p, "_empty"}, empty_o, (m_cnt[k] == 0) ? 1 : 0);
        check({p, "_afull"}, af_o, (m_cnt[k] >= AFLVL[k]) ? 1 : 0);
        check({p, "_we"},    we_o, push_ok);
        check({p, "_waddr"}, waddr_o, m_wp[k]);
        check({p, "_re"},    re_o, pop_ok);
        check({p, "_raddr"}, raddr_o, m_rp[k]);
        check({p, "_rvalid"}, rv_o, exp_rv);
        if (i_clr) begin
            m_cnt[k] = 0; m_wp[k] = 0; m_rp[k] = 0; m_rv[k] = 0;
        end else begin
            m_cnt[k] = m_cnt[k] + push_ok - pop_ok;
            m_wp[k]  = (m_wp[k] + push_ok) % DEPTH[k];
            m_rp[k]  = (m_rp[k] + pop_ok) % DEPTH[k];
            m_rv[k]  = pop_ok;
        end
    endtask

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] = 0; m_wp[k] = 0; m_rp[k] = 0; m_rv[k] = 0;
            end
        end else begin
            model_cycle(0, int'(a_count), int'(a_full), int'(a_empty), int'(a_af), int'(a_we),
                        int'(a_waddr), int'(a_re), int'(a_raddr), int'(a_rvalid));
            model_cycle(1, int'(b_count), int'(b_full), int'(b_empty), int'(b_af), int'(b_we),
                        int'(b_waddr), int'(b_re), int'(b_raddr), int'(b_rvalid));
        end
    end

    // Apply one cycle of requests just after the rising edge; returns once outputs have settled.
    task automatic step(input bit p, input bit q, input bit c);
        @(posedge clk);
        #1;
        i_push = p;
        i_pop  = q;
        i_clr  = c;
        #1;
    endtask

    task automatic reset_pulse();
        #1 rst = 1'b0;
        #1;
        check("mid_reset_count", int'(a_count), 0);
        check("mid_reset_empty", int'(a_empty), 1);
        check("mid_reset_d5_empty", int'(b_empty), 1);
        #1 rst = 1'b1;
    endtask

    initial begin
        int push_pct, pop_pct;
        bit p, q, c;

        #4;
        check("reset_count", int'(a_count), 0);
        check("reset_empty", int'(a_empty), 1);
        check("reset_full", int'(a_full), 0);
        check("reset_afull", int'(a_af), 0);
        check("reset_rvalid", int'(a_rvalid), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Fill the 8-deep FIFO and try one push too many.
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0);
            check("fill_we", int'(a_we), 1);
            check("fill_waddr", int'(a_waddr), i);
            check("fill_count", int'(a_count), i);
            check("fill_afull", int'(a_af), (i >= 7) ? 1 : 0);
            check("fill_full", int'(a_full), 0);
        end
        step(1, 0, 0);
        check("overfill_we", int'(a_we), 0);
        check("overfill_count", int'(a_count), 8);
        check("overfill_full", int'(a_full), 1);
        check("overfill_waddr", int'(a_waddr), 0);
        check("d5_full_count", int'(b_count), 5);
        check("d5_full_flag", int'(b_full), 1);
        check("d5_wrap_waddr", int'(b_waddr), 0);

        // Drain it and try one pop too many.
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0);
            check("drain_re", int'(a_re), 1);
            check("drain_raddr", int'(a_raddr), i);
            check("drain_count", int'(a_count), 8 - i);
            check("drain_rvalid", int'(a_rvalid), (i > 0) ? 1 : 0);
            check("d5_drain_rvalid", int'(b_rvalid), (i < 5) ? 1 : 0);
        end
        step(0, 1, 0);
        check("underflow_re", int'(a_re), 0);
        check("underflow_empty", int'(a_empty), 1);
        check("underflow_rvalid", int'(a_rvalid), 1);

        // Empty with push+pop: write only.
        step(1, 1, 0);
        check("empty_pp_we", int'(a_we), 1);
        check("empty_pp_re", int'(a_re), 0);
        check("empty_pp_rvalid", int'(a_rvalid), 0);
        step(0, 0, 0);
        check("empty_pp_count", int'(a_count), 1);
        check("empty_pp_not_empty", int'(a_empty), 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0);

        // Full with push+pop: read only.
        step(1, 1, 0);
        check("full_pp_count", int'(a_count), 8);
        check("full_pp_we", int'(a_we), 0);
        check("full_pp_re", int'(a_re), 1);
        step(0, 0, 0);
        check("full_pp_after", int'(a_count), 7);

        // Clear at count 3 overrides push and pop.
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        step(1, 1, 1);
        check("clr_count_before", int'(a_count), 3);
        check("clr_we", int'(a_we), 0);
        check("clr_re", int'(a_re), 0);
        step(0, 0, 0);
        check("clr_count", int'(a_count), 0);
        check("clr_empty", int'(a_empty), 1);
        check("clr_waddr", int'(a_waddr), 0);
        check("clr_raddr", int'(a_raddr), 0);
        check("clr_rvalid", int'(a_rvalid), 0);

        // Asynchronous reset between edges at count 4.
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        step(0, 0, 0);
        check("pre_reset_count", int'(a_count), 4);
        reset_pulse();

        // Randomized traffic with shifting push/pop bias, rare clears and resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 200 == 0) begin
                push_pct = $urandom_range(10, 90);
                pop_pct  = $urandom_range(10, 90);
            end
            p = ($urandom_range(0, 99) < push_pct);
            q = ($urandom_range(0, 99) < pop_pct);
            c = ($urandom_range(0, 99) < 2);
            step(p, q, c);
            if ($urandom_range(0, 499) == 0) reset_pulse();
        end

        step(0, 0, 0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
